pc_pipe_unit: RTL and testbench
===============================

Name: pc_pipe_unit

Overview:
- Parametrised successor to the team's single PC flip-flop.
- Generates the fetch PC and carries PC/valid pairs through the IF, ID and EX stages.
- Handles reset vector, stall, branch/jump redirect, exception redirect and misaligned-target detection.
- Sits at the front of the pipelined CPU: feeds instruction-memory address, hazard unit drives stall, EX stage drives redirect.

Parameters:
- DATA_WIDTH, 32, width of every PC value.
- RESET_PC, 32'h0000_3000, PC value presented at IF in the first cycle after reset deasserts.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- INST_BYTES, 4, sequential PC increment; power of two; the low log2(INST_BYTES) bits of every PC are zero.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- stall, input, 1, load-use hazard: hold PC and ID, inject bubble into EX.
- br_valid, input, 1, EX-stage redirect request (taken branch or jump).
- br_target, input, DATA_WIDTH, redirect address; qualified by br_valid.
- exc_valid, input, 1, exception redirect to EXC_VECTOR.
- pc_if, output, DATA_WIDTH, current fetch address.
- pc_plus_inc, output, DATA_WIDTH, pc_if + INST_BYTES, combinational (link-address use).
- pc_id, output, DATA_WIDTH, PC of the instruction in ID.
- valid_id, output, 1, ID holds a real instruction.
- pc_ex, output, DATA_WIDTH, PC of the instruction in EX.
- valid_ex, output, 1, EX holds a real instruction.
- misalign, output, 1, registered one-cycle pulse: last accepted br_target had nonzero low bits.

Behaviour:
- Reset: every output is registered except pc_plus_inc.
  - Cycle after rst=1: pc_if=RESET_PC, pc_id=0, pc_ex=0, valid_id=0, valid_ex=0, misalign=0.
  - rst overrides every other input, including mid-redirect and mid-stall.
- pc_if next-value priority, highest first:
  - rst -> RESET_PC
  - exc_valid -> EXC_VECTOR
  - br_valid -> br_target with its low log2(INST_BYTES) bits forced to 0
  - stall -> hold
  - otherwise -> pc_if + INST_BYTES.
- Arithmetic: increment is modulo 2^DATA_WIDTH. The last aligned address wraps to 0 with no flag.
- ID stage:
  - rst, exc_valid or br_valid -> valid_id<=0 (pc_id is don't-care, implementation holds it).
  - else stall -> hold pc_id and valid_id.
  - else -> pc_id<=pc_if, valid_id<=1.
- EX stage:
  - rst, exc_valid, br_valid or stall -> valid_ex<=0 (bubble).
  - else -> pc_ex<=pc_id, valid_ex<=valid_id.
- Simultaneous events:
  - exc_valid with br_valid: exception wins; misalign is not raised.
  - br_valid with stall: redirect wins; ID is flushed, not held.
- misalign <= br_valid & ~exc_valid & ~rst & (br_target low bits != 0). Cleared the following cycle unless the condition repeats.
- Latency:
  - Redirect reaches pc_if 1 cycle after br_valid.
  - First valid_id is 1 cycle after the first post-reset fetch.
  - First valid_ex is 2 cycles after the first post-reset fetch.
- No combinational path from any input to a registered output. pc_plus_inc depends only on pc_if.

Decomposition:
- Shared cpu package holds:
  - constants RESET_PC_DEFAULT and EXC_VECTOR_DEFAULT
  - INST_BYTES
  - typedef pc_t (logic [DATA_WIDTH-1:0])
  - struct stage_pc_t {pc, valid}.
- One natural sub-module, pc_stage_reg: a pc_t+valid register with hold, flush and bubble controls, instantiated for ID and EX.
- The PC register itself stays in the top module.

Test Plan:
1. Reset then free run, 4 cycles, no stall/redirect:
   - pc_if: 3000, 3004, 3008, 300C
   - pc_id trails by 1 cycle; pc_ex trails by 2 cycles
   - valid_id rises cycle 2; valid_ex rises cycle 3.
2. stall=1 for 2 cycles at pc_if=3008:
   - pc_if holds 3008; pc_id holds 3004
   - valid_ex=0 for 2 cycles
   - on release: pc_if=300C, pc_ex=3004.
3. br_valid=1, br_target=0x3100 while pc_if=3010:
   - next cycle pc_if=3100, valid_id=0, valid_ex=0
   - following cycle pc_id=3100, valid_id=1.
4. br_valid=1, br_target=0x3102:
   - pc_if=3100; misalign=1 for exactly one cycle.
5. exc_valid=1 with br_valid=1, stall=1, br_target=0x3002:
   - pc_if=4180; misalign=0; both stages invalid.
6. DATA_WIDTH=16, RESET_PC=16'hFFF8:
   - pc_if sequence FFF8, FFFC, 0000, no flag.
   - rst asserted during a stall gives pc_if=FFF8 next cycle, valid_id=0, valid_ex=0.

Source files
------------

// File: rtl/pc_pipe_unit_pkg.sv
// pc_pipe_unit_pkg: shared fetch/pipeline constants and PC types
package pc_pipe_unit_pkg;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
  localparam int INST_BYTES = 4;
  typedef logic [DATA_WIDTH_DEFAULT-1:0] pc_t;
  typedef struct packed {
    pc_t  pc;
    logic valid;
  } stage_pc_t;
endpackage

// File: rtl/pc_pipe_unit_if.sv
// pc_pipe_unit_if: control inputs and PC outputs of the fetch/pipe unit
interface pc_pipe_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  stall;
  logic                  br_valid;
  logic [DATA_WIDTH-1:0] br_target;
  logic                  exc_valid;
  logic [DATA_WIDTH-1:0] pc_if;
  logic [DATA_WIDTH-1:0] pc_plus_inc;
  logic [DATA_WIDTH-1:0] pc_id;
  logic                  valid_id;
  logic [DATA_WIDTH-1:0] pc_ex;
  logic                  valid_ex;
  logic                  misalign;
  modport master (
    output stall, br_valid, br_target, exc_valid,
    input  pc_if, pc_plus_inc, pc_id, valid_id, pc_ex, valid_ex, misalign
  );
  modport slave (
    input  stall, br_valid, br_target, exc_valid,
    output pc_if, pc_plus_inc, pc_id, valid_id, pc_ex, valid_ex, misalign
  );
endinterface

// File: rtl/pc_pipe_unit_stage_reg.sv
// pc_stage_reg: PC/valid pipeline register with reset, flush and hold
module pc_stage_reg #(parameter int DATA_WIDTH = 32) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] d_pc,
  input  logic                  d_valid,
  output logic [DATA_WIDTH-1:0] q_pc,
  output logic                  q_valid
);
  // flush kills the slot but keeps the stale PC; hold freezes both fields
  always_ff @(posedge clk) begin
    if (rst) begin
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (!hold) begin
      q_pc    <= d_pc;
      q_valid <= d_valid;
    end
  end
endmodule

// File: rtl/pc_pipe_unit.sv
// pc_pipe_unit: fetch PC generation and IF/ID/EX PC-valid tracking
module pc_pipe_unit #(
  parameter int                    DATA_WIDTH = pc_pipe_unit_pkg::DATA_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(pc_pipe_unit_pkg::RESET_PC_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = DATA_WIDTH'(pc_pipe_unit_pkg::EXC_VECTOR_DEFAULT),
  parameter int                    INST_BYTES = pc_pipe_unit_pkg::INST_BYTES
) (
  input logic         clk,
  input logic         rst,
  pc_pipe_unit_if.slave bus
);
  import pc_pipe_unit_pkg::*;
  localparam logic [DATA_WIDTH-1:0] INC  = DATA_WIDTH'(INST_BYTES);
  localparam logic [DATA_WIDTH-1:0] LOWM = DATA_WIDTH'(INST_BYTES - 1);
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic                  redirect, low_bits;
  assign redirect        = bus.exc_valid | bus.br_valid;
  assign low_bits        = |(bus.br_target & LOWM);
  assign bus.pc_if       = pc;
  assign bus.pc_plus_inc = pc + INC;
  // exception beats branch beats stall beats sequential increment
  always_comb
    pc_nxt = bus.exc_valid ? EXC_VECTOR :
             bus.br_valid  ? (bus.br_target & ~LOWM) :
             bus.stall     ? pc : pc + INC;
  // fetch PC and the one-cycle misaligned-target pulse
  always_ff @(posedge clk) begin
    pc       <= rst ? RESET_PC : pc_nxt;
    bus.misalign <= ~rst & bus.br_valid & ~bus.exc_valid & low_bits;
  end
  pc_stage_reg #(.DATA_WIDTH(DATA_WIDTH)) u_id (
    .clk(clk), .rst(rst), .flush(redirect), .hold(bus.stall),
    .d_pc(pc), .d_valid(1'b1), .q_pc(bus.pc_id), .q_valid(bus.valid_id)
  );
  pc_stage_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ex (
    .clk(clk), .rst(rst), .flush(redirect | bus.stall), .hold(1'b0),
    .d_pc(bus.pc_id), .d_valid(bus.valid_id), .q_pc(bus.pc_ex), .q_valid(bus.valid_ex)
  );
endmodule

// File: tb/tb_pc_pipe_unit.sv
// tb_pc_pipe_unit: directed checks of fetch PC, stage tracking and redirects
module tb_pc_pipe_unit;
  logic clk = 1'b0;
  logic rst, rst16;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pc_pipe_unit_if #(.DATA_WIDTH(32)) b32 ();
  pc_pipe_unit_if #(.DATA_WIDTH(16)) b16 ();
  pc_pipe_unit dut (.clk(clk), .rst(rst), .bus(b32));
  pc_pipe_unit #(.DATA_WIDTH(16), .RESET_PC(16'hFFF8), .EXC_VECTOR(16'h0180), .INST_BYTES(4))
    dut16 (.clk(clk), .rst(rst16), .bus(b16));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic stage32(input string tag, input logic [31:0] pif, input logic [31:0] pid,
                         input logic vid, input logic [31:0] pex, input logic vex);
    chk({tag, ".pc_if"}, b32.pc_if, pif);
    if (vid) chk({tag, ".pc_id"}, b32.pc_id, pid);
    chk({tag, ".valid_id"}, {31'd0, b32.valid_id}, {31'd0, vid});
    if (vex) chk({tag, ".pc_ex"}, b32.pc_ex, pex);
    chk({tag, ".valid_ex"}, {31'd0, b32.valid_ex}, {31'd0, vex});
  endtask
  initial begin
    rst = 1'b1; rst16 = 1'b1;
    b32.stall = 0; b32.br_valid = 0; b32.br_target = '0; b32.exc_valid = 0;
    b16.stall = 0; b16.br_valid = 0; b16.br_target = '0; b16.exc_valid = 0;
    step();
    stage32("rst", 32'h3000, 0, 0, 0, 0);
    chk("rst.pc_id", b32.pc_id, 32'h0);
    chk("rst.pc_ex", b32.pc_ex, 32'h0);
    chk("rst.misalign", {31'd0, b32.misalign}, 32'h0);
    chk("rst.pc_plus_inc", b32.pc_plus_inc, 32'h3004);
    rst = 1'b0;
    step(); stage32("run1", 32'h3004, 32'h3000, 1, 0, 0);
    step(); stage32("run2", 32'h3008, 32'h3004, 1, 32'h3000, 1);
    b32.stall = 1;
    step(); stage32("stall1", 32'h3008, 32'h3004, 1, 0, 0);
    step(); stage32("stall2", 32'h3008, 32'h3004, 1, 0, 0);
    b32.stall = 0;
    step(); stage32("release", 32'h300C, 32'h3008, 1, 32'h3004, 1);
    step(); stage32("run3", 32'h3010, 32'h300C, 1, 32'h3008, 1);
    b32.br_valid = 1; b32.br_target = 32'h3100;
    step(); stage32("br", 32'h3100, 0, 0, 0, 0);
    chk("br.misalign", {31'd0, b32.misalign}, 32'h0);
    b32.br_valid = 0;
    step(); stage32("br_next", 32'h3104, 32'h3100, 1, 0, 0);
    b32.br_valid = 1; b32.br_target = 32'h3102;
    step(); stage32("mis", 32'h3100, 0, 0, 0, 0);
    chk("mis.misalign", {31'd0, b32.misalign}, 32'h1);
    b32.br_valid = 0;
    step();
    chk("mis_clr.misalign", {31'd0, b32.misalign}, 32'h0);
    chk("mis_clr.pc_if", b32.pc_if, 32'h3104);
    b32.exc_valid = 1; b32.br_valid = 1; b32.stall = 1; b32.br_target = 32'h3002;
    step(); stage32("exc", 32'h4180, 0, 0, 0, 0);
    chk("exc.misalign", {31'd0, b32.misalign}, 32'h0);
    b32.exc_valid = 0; b32.br_valid = 0; b32.stall = 0;
    step(); stage32("exc_next", 32'h4184, 32'h4180, 1, 0, 0);
    chk("exc_next.pc_plus_inc", b32.pc_plus_inc, 32'h4188);
    b32.br_valid = 1; b32.br_target = 32'h3203; b32.stall = 1;
    step(); stage32("br_stall", 32'h3200, 0, 0, 0, 0);
    chk("br_stall.misalign", {31'd0, b32.misalign}, 32'h1);
    b32.br_target = 32'h5000; b32.stall = 0; rst = 1;
    step(); stage32("rst_br", 32'h3000, 0, 0, 0, 0);
    chk("rst_br.misalign", {31'd0, b32.misalign}, 32'h0);
    b32.br_valid = 0; rst = 0;
    chk("w16.rst", {16'd0, b16.pc_if}, 32'hFFF8);
    rst16 = 0;
    step(); chk("w16.seq1", {16'd0, b16.pc_if}, 32'hFFFC);
    step(); chk("w16.wrap", {16'd0, b16.pc_if}, 32'h0000);
    chk("w16.misalign", {31'd0, b16.misalign}, 32'h0);
    chk("w16.pc_plus_inc", {16'd0, b16.pc_plus_inc}, 32'h0004);
    chk("w16.pc_id", {16'd0, b16.pc_id}, 32'hFFFC);
    b16.stall = 1;
    step(); chk("w16.stall", {16'd0, b16.pc_if}, 32'h0000);
    rst16 = 1;
    step();
    chk("w16.rst_stall.pc_if", {16'd0, b16.pc_if}, 32'hFFF8);
    chk("w16.rst_stall.valid_id", {31'd0, b16.valid_id}, 32'h0);
    chk("w16.rst_stall.valid_ex", {31'd0, b16.valid_ex}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
